// File: rtl/data_mem_sequencer_pkg.sv
// Shared types and constants for the byte-serial data memory sequencer.
package data_mem_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdLast,
        StDone
    } seq_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WR_LAT         = 5;
    localparam int unsigned RD_LAT         = 6;

endpackage

// File: rtl/data_mem_sequencer_byte_ram.sv
// Byte-wide single-port storage with synchronous read; rst clears only the read register.
module data_mem_sequencer_byte_ram #(
    parameter int unsigned BIT_NUMBER = 8,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         addr_i,
    input  logic [BIT_NUMBER-1:0] wdata_i,
    input  logic                  we_i,
    input  logic                  re_i,
    output logic [BIT_NUMBER-1:0] rdata_o
);

    logic [BIT_NUMBER-1:0] mem_q [DEPTH];
    logic [BIT_NUMBER-1:0] rdata_q;

    // Contents survive reset so an aborted store leaves its earlier bytes in place.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_sequencer.sv
// Sequences 32-bit word loads/stores onto a byte-wide synchronous store, stalling the pipeline.
module data_mem_sequencer
    import data_mem_sequencer_pkg::*;
#(
    parameter int unsigned BIT_NUMBER = 8,
    parameter int unsigned MEM_VOL    = 1024,
    parameter int unsigned BASE_ADDR  = 1024,
    parameter int unsigned AW         = $clog2(4 * MEM_VOL)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_r_en_i,
    input  logic                                 req_w_en_i,
    input  logic [31:0]                          req_addr_i,
    input  logic [BYTES_PER_WORD*BIT_NUMBER-1:0] req_wdata_i,
    output logic [BYTES_PER_WORD*BIT_NUMBER-1:0] rdata_o,
    output logic                                 ready_o,
    output logic                                 err_o,
    output logic [AW-1:0]                        mem_addr_o,
    output logic [BIT_NUMBER-1:0]                mem_wdata_o,
    output logic                                 mem_we_o,
    output logic                                 mem_re_o,
    input  logic [BIT_NUMBER-1:0]                mem_rdata_i
);

    localparam int unsigned WW = BYTES_PER_WORD * BIT_NUMBER;

    seq_state_e            state_q;
    logic [1:0]            beat_q;
    logic [AW-3:0]         word_q;
    logic [WW-1:0]         wdata_q;
    logic [WW-1:0]         rdata_q;
    logic                  err_q;
    logic                  err_pend_q;
    logic                  mem_we_q;
    logic                  mem_re_q;
    logic [AW-1:0]         mem_addr_q;
    logic [BIT_NUMBER-1:0] mem_wdata_q;

    logic [31:0] local_addr;
    logic        out_of_range;
    logic [1:0]  beat_nxt;
    logic [1:0]  beat_prev;

    always_comb begin
        // Addresses below the base wrap to large values and fail the range check.
        local_addr   = req_addr_i - 32'(BASE_ADDR);
        out_of_range = local_addr >= 32'(BYTES_PER_WORD * MEM_VOL);
        beat_nxt     = beat_q + 2'd1;
        beat_prev    = beat_q - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= 2'd0;
            word_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            err_pend_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_r_en_i || req_w_en_i) begin
                        word_q  <= local_addr[AW-1:2];
                        wdata_q <= req_wdata_i;
                        beat_q  <= 2'd0;
                        if (out_of_range) begin
                            state_q <= StDone;
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end else if (req_w_en_i) begin
                            // Write wins a simultaneous read; the conflict is reported at DONE.
                            state_q     <= StWr;
                            err_pend_q  <= req_r_en_i;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {local_addr[AW-1:2], 2'b00};
                            mem_wdata_q <= req_wdata_i[BIT_NUMBER-1:0];
                        end else begin
                            state_q    <= StRd;
                            err_pend_q <= 1'b0;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= {local_addr[AW-1:2], 2'b00};
                        end
                    end
                end
                StWr: begin
                    if (beat_q == 2'd3) begin
                        state_q  <= StDone;
                        mem_we_q <= 1'b0;
                        err_q    <= err_pend_q;
                    end else begin
                        beat_q      <= beat_nxt;
                        mem_addr_q  <= {word_q, beat_nxt};
                        mem_wdata_q <= wdata_q[beat_nxt*BIT_NUMBER +: BIT_NUMBER];
                    end
                end
                StRd: begin
                    // Read data lags its strobe by one cycle.
                    if (beat_q != 2'd0) begin
                        rdata_q[beat_prev*BIT_NUMBER +: BIT_NUMBER] <= mem_rdata_i;
                    end
                    if (beat_q == 2'd3) begin
                        state_q  <= StRdLast;
                        mem_re_q <= 1'b0;
                    end else begin
                        beat_q     <= beat_nxt;
                        mem_addr_q <= {word_q, beat_nxt};
                    end
                end
                StRdLast: begin
                    rdata_q[3*BIT_NUMBER +: BIT_NUMBER] <= mem_rdata_i;
                    state_q <= StDone;
                    err_q   <= err_pend_q;
                end
                StDone: begin
                    state_q <= StIdle;
                    err_q   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o     = ((state_q == StIdle) && !req_r_en_i && !req_w_en_i) ||
                         (state_q == StDone);
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Directed self-checking bench: sequencer plus byte store, hand-computed expectations.
module tb_data_mem_sequencer;

    logic        clk;
    logic        rst;
    logic        req_r_en;
    logic        req_w_en;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req_r_en_i  (req_r_en),
        .req_w_en_i  (req_w_en),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rdata_o     (rdata),
        .ready_o     (ready),
        .err_o       (err),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_re_o    (mem_re),
        .mem_rdata_i (mem_rdata)
    );

    data_mem_sequencer_byte_ram #(
        .BIT_NUMBER (8),
        .DEPTH      (4096),
        .AW         (12)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .rdata_o (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Results of the last transaction, gathered at negedges.
    int          t_stall;
    int          t_nwe;
    int          t_nre;
    int          t_first_we_cyc;
    int          t_first_re_cyc;
    logic [11:0] t_first_addr;
    logic [11:0] t_last_addr;
    logic [31:0] t_wbytes;
    logic [31:0] t_rdata;
    logic        t_err;
    logic        t_err_after;

    task automatic run_txn(input string tag, input logic r, input logic w,
                           input logic [31:0] addr, input logic [31:0] data);
        int   cyc;
        logic timed_out;
        @(posedge clk);
        #1;
        req_r_en  = r;
        req_w_en  = w;
        req_addr  = addr;
        req_wdata = data;
        t_stall = 0; t_nwe = 0; t_nre = 0;
        t_first_we_cyc = -1; t_first_re_cyc = -1;
        t_first_addr = '0; t_last_addr = '0; t_wbytes = '0;
        cyc = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_we || mem_re) begin
                if (t_nwe == 0 && t_nre == 0) t_first_addr = mem_addr;
                t_last_addr = mem_addr;
            end
            if (mem_we) begin
                if (t_nwe == 0) t_first_we_cyc = cyc;
                if (t_nwe < 4) t_wbytes[t_nwe*8 +: 8] = mem_wdata;
                t_nwe++;
            end
            if (mem_re) begin
                if (t_nre == 0) t_first_re_cyc = cyc;
                t_nre++;
            end
            if (ready) break;
            t_stall++;
            cyc++;
            if (cyc > 20) begin
                timed_out = 1'b1;
                break;
            end
        end
        t_rdata = rdata;
        t_err   = err;
        check_eq({tag, "_timeout"}, 32'(timed_out), 32'd0);
        @(posedge clk);
        #1;
        req_r_en = 1'b0;
        req_w_en = 1'b0;
        @(negedge clk);
        t_err_after = err;
    endtask

    initial begin
        rst = 1'b1;
        req_r_en = 1'b0;
        req_w_en = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        #12;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_txn("st2000", 1'b0, 1'b1, 32'd1024, 32'h0000_2000);
        check_eq("st2000_stall", 32'(t_stall), 32'd5);
        check_eq("st2000_nwe", 32'(t_nwe), 32'd4);
        check_eq("st2000_we_cyc", 32'(t_first_we_cyc), 32'd1);
        check_eq("st2000_addr0", 32'(t_first_addr), 32'd0);
        check_eq("st2000_addr3", 32'(t_last_addr), 32'd3);
        check_eq("st2000_bytes", t_wbytes, 32'h0000_2000);
        check_eq("st2000_err", 32'(t_err), 32'd0);

        run_txn("ld2000", 1'b1, 1'b0, 32'd1024, 32'h0);
        check_eq("ld2000_stall", 32'(t_stall), 32'd6);
        check_eq("ld2000_nre", 32'(t_nre), 32'd4);
        check_eq("ld2000_re_cyc", 32'(t_first_re_cyc), 32'd1);
        check_eq("ld2000_rdata", t_rdata, 32'h0000_2000);
        check_eq("ld2000_err", 32'(t_err), 32'd0);
        check_eq("idle_ready", 32'(ready), 32'd1);

        run_txn("st_unal", 1'b0, 1'b1, 32'd1030, 32'hC000_0000);
        check_eq("st_unal_addr0", 32'(t_first_addr), 32'd4);
        check_eq("st_unal_addr3", 32'(t_last_addr), 32'd7);
        check_eq("st_unal_bytes", t_wbytes, 32'hC000_0000);
        run_txn("ld_unal", 1'b1, 1'b0, 32'd1028, 32'h0);
        check_eq("ld_unal_rdata", t_rdata, 32'hC000_0000);

        run_txn("oor_low", 1'b1, 1'b0, 32'd0, 32'h0);
        check_eq("oor_low_stall", 32'(t_stall), 32'd1);
        check_eq("oor_low_strobes", 32'(t_nre + t_nwe), 32'd0);
        check_eq("oor_low_rdata", t_rdata, 32'd0);
        check_eq("oor_low_err", 32'(t_err), 32'd1);
        check_eq("oor_low_err_pulse", 32'(t_err_after), 32'd0);
        run_txn("oor_high", 1'b1, 1'b0, 32'd5120, 32'h0);
        check_eq("oor_high_stall", 32'(t_stall), 32'd1);
        check_eq("oor_high_strobes", 32'(t_nre + t_nwe), 32'd0);
        check_eq("oor_high_err", 32'(t_err), 32'd1);

        run_txn("both", 1'b1, 1'b1, 32'd1032, 32'hFFFF_FF85);
        check_eq("both_stall", 32'(t_stall), 32'd5);
        check_eq("both_nwe", 32'(t_nwe), 32'd4);
        check_eq("both_nre", 32'(t_nre), 32'd0);
        check_eq("both_err", 32'(t_err), 32'd1);
        check_eq("both_err_pulse", 32'(t_err_after), 32'd0);
        run_txn("ld_both", 1'b1, 1'b0, 32'd1032, 32'h0);
        check_eq("ld_both_rdata", t_rdata, 32'hFFFF_FF85);
        check_eq("ld_both_err", 32'(t_err), 32'd0);

        // Seed 1040 so the bytes an aborted store never reaches are recognisable.
        run_txn("seed", 1'b0, 1'b1, 32'd1040, 32'hAABB_CCDD);
        @(posedge clk);
        #1;
        req_w_en  = 1'b1;
        req_addr  = 32'd1040;
        req_wdata = 32'h1122_3344;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_we", 32'(mem_we), 32'd0);
        check_eq("abort_ready_req", 32'(ready), 32'd0);
        req_w_en = 1'b0;
        #1;
        check_eq("abort_ready_idle", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_txn("ld_abort", 1'b1, 1'b0, 32'd1040, 32'h0);
        check_eq("ld_abort_rdata", t_rdata, 32'hAABB_3344);

        run_txn("st_post", 1'b0, 1'b1, 32'd1040, 32'h1122_3344);
        check_eq("st_post_stall", 32'(t_stall), 32'd5);
        check_eq("st_post_err", 32'(t_err), 32'd0);
        run_txn("ld_post", 1'b1, 1'b0, 32'd1040, 32'h0);
        check_eq("ld_post_rdata", t_rdata, 32'h1122_3344);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_sequencer.md
Name: data_mem_sequencer

Overview:
Sequences 32-bit word load/store requests from the pipeline MEM stage onto a byte-wide, single-port, synchronous-read data store, one byte per cycle. Holds the pipeline through the `ready` signal (freeze) until the word transfer completes. Translates the CPU address into a local byte address and aligns it to a word boundary. Flags out-of-range and conflicting requests. Sits between the MEM stage and the data storage array.

Parameters:
BIT_NUMBER, 8, byte width; word = 4*BIT_NUMBER
MEM_VOL, 1024, words of storage (4*MEM_VOL bytes)
BASE_ADDR, 1024, CPU byte address mapped to local byte 0
AW, $clog2(4*MEM_VOL), local byte-address width (12 at defaults)

Ports:
clk  in  1  clock
rst  in  1  reset
req_r_en  in  1  load request; held stable while ready=0
req_w_en  in  1  store request; held stable while ready=0
req_addr  in  32  CPU byte address
req_wdata  in  4*BIT_NUMBER  store data
rdata  out  4*BIT_NUMBER  load result; valid only in DONE cycle
ready  out  1  0 = stall pipeline
err  out  1  error pulse in DONE cycle
mem_addr  out  AW  byte address to storage
mem_wdata  out  BIT_NUMBER  byte write data
mem_we  out  1  byte write strobe
mem_re  out  1  byte read strobe
mem_rdata  in  BIT_NUMBER  storage read data; valid the cycle after mem_re

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Reset values: state IDLE, beat=0, rdata=0, err=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- Combinational ready = (state==IDLE & ~req_r_en & ~req_w_en) | state==DONE.
- local = req_addr - BASE_ADDR. wbase = {local[AW-1:2], 2'b00}.
- Range check: out-of-range if local ≥ 4*MEM_VOL (unsigned; addresses below BASE_ADDR wrap high and fail).
- Byte order is little-endian: beat i moves bits [8i+7:8i] at wbase+i.
- States are IDLE, WR, RD, RD_LAST, DONE. Beat counter is 2 bits.
- IDLE transitions:
  - If req_w_en is set, latch addr and data and go to WR. This includes req_r_en & req_w_en together: the write wins and err is set in DONE.
  - Else if req_r_en is set, go to RD.
  - Out-of-range requests go straight to DONE: no storage strobes, rdata=0, err=1.
- WR: each cycle drive mem_we=1, mem_addr=wbase+beat, mem_wdata=byte[beat]. After beat 3, go to DONE.
- RD: each cycle drive mem_re=1, mem_addr=wbase+beat. In the following cycle, capture mem_rdata into rdata byte[beat-1]. After issuing beat 3, go to RD_LAST.
- RD_LAST: capture byte 3. No strobes. Go to DONE.
- DONE: ready=1. rdata and err are valid for this one cycle. The pipeline advances at this edge. Next state is IDLE.
  - A request present in the next cycle is a new transaction; there is no back-to-back bypass.
- Stall timing, with the request first seen in cycle 0:
  - Store: ready low in cycles 0–4, high in cycle 5.
  - Load: ready low in cycles 0–5, high in cycle 6.
  - Out-of-range: ready low in cycle 0, high in cycle 1.
- Between transactions, rdata holds its last value. Only the DONE cycle is architecturally valid.
- rst mid-transaction aborts immediately. Strobes drop asynchronously. Bytes already written remain in storage (no rollback).
- Request de-asserted mid-transaction is a protocol violation. The sequencer completes from latched values regardless.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WR, RD, RD_LAST, DONE)
  - BYTES_PER_WORD=4
  - latency constants WR_LAT=5, RD_LAT=6
- One natural sub-module: byte_ram, a byte-wide single-port storage with synchronous read and async-clear on rst. It is instantiated beside the sequencer in the memory stage and reused by the bench.

Test Plan:
- Store 0x00002000 to 1024: mem_we pulses cycles 1–4 at local 0..3 with bytes 00,20,00,00; ready high only in cycle 5; err=0.
- Load from 1024 after that store: mem_re in cycles 1–4; rdata=0x00002000 and ready=1 in cycle 6; err=0.
- Store 0xC0000000 to 1030 (unaligned): written at local 4..7 as 00,00,00,C0. Load from 1028 returns 0xC0000000.
- Load from 0x00000000 (below base) and from 1024+4096: no strobes; DONE in cycle 1 with rdata=0, err=1.
- req_r_en=req_w_en=1, addr 1032, data 0xFFFFFF85: performs the write; err=1 in DONE. A subsequent load returns 0xFFFFFF85.
- Assert rst in cycle 3 of a store of 0x11223344 to 1040: mem_we=0 and ready recomputes from IDLE immediately. Local bytes 16,17 = 44,33 and 18,19 are unchanged. A new store after reset completes normally.
